udp_tx_payload_serializer: RTL
==============================

Name: udp_tx_payload_serializer

Overview:
- Multi-channel successor to the UDP send-path glue: accepts up to NUM_CH wide payload descriptors (parallel data plus byte length) and serialises them into one byte stream with valid/ready/last.
- The stream feeds the UDP packet builder.
- Replaces the fixed 16-stage OR pulse stretcher with a parametrised per-channel completion stretcher, so slower logic can sample end-of-frame.
- Single clock domain: rgmii_clk.

Parameters:
- NUM_CH, 2, number of payload source channels (1..8).
- BYTES, 120, payload register width in bytes (data bus per channel = BYTES*8).
- LEN_W, 16, width of the length fields.
- GAP_CYCLES, 12, minimum idle cycles between frames on tx (0 allowed).
- DONE_STRETCH, 16, cycles each done_stretch bit stays high (>=1).

Ports:
- rgmii_clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  NUM_CH  per-channel descriptor valid.
- in_ready  out  NUM_CH  per-channel accept; at most one bit high per cycle.
- in_data  in  NUM_CH*BYTES*8  channel c occupies bits [c*BYTES*8 +: BYTES*8].
- in_length  in  NUM_CH*LEN_W  channel c occupies bits [c*LEN_W +: LEN_W]; payload byte count.
- tx_valid  out  1  byte stream valid.
- tx_ready  in  1  byte stream ready from the packet builder.
- tx_data  out  8  payload byte.
- tx_last  out  1  high with the final byte of a frame.
- tx_length  out  LEN_W  effective (clamped) frame length; stable for the whole frame.
- tx_chan  out  max(1,$clog2(NUM_CH))  source channel of the current frame.
- done_stretch  out  NUM_CH  per-channel stretched completion flag.
- len_err  out  1  sticky: some descriptor had length > BYTES.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer = 0; all counters 0.
- rst mid-frame aborts the frame immediately: tx_valid drops the next cycle and no tx_last is issued.
- States:
  - IDLE: grant goes to the first channel with in_valid, searching from the pointer upward with wrap.
  - SEND: frame bytes are presented on tx.
  - GAP: mandatory idle between frames.
- in_ready[g] is combinational: high only when state is IDLE, g is granted, and rst is low. A transfer occurs on the in_valid&in_ready edge.
- On transfer:
  - latch in_data[g] into the shift register; latch len = min(in_length[g], BYTES).
  - set tx_chan = g; advance the pointer to g+1 mod NUM_CH.
  - set len_err to 1 if in_length[g] > BYTES.
- Length 0: the descriptor is accepted, no tx bytes are produced, the done pulse still fires, and the FSM goes to GAP (or IDLE if GAP_CYCLES == 0).
- SEND:
  - tx_valid is high from the cycle after the transfer (latency 1).
  - Byte order is MSB-first: byte k = latched bits [BYTES*8-1-8k -: 8].
  - The byte index advances only on tx_valid&tx_ready.
  - tx_last = (index == len-1).
  - While tx_ready is low, tx_data, tx_last, tx_length and tx_chan hold.
- On the last handshake, go to GAP and count GAP_CYCLES cycles, then go to IDLE. If GAP_CYCLES == 0, go straight to IDLE.
- Channel arbitration inputs are ignored outside IDLE. in_ready stays 0 there, and in_valid is expected to hold until accepted.
- done_stretch[c]:
  - A 1-cycle done event for channel c (last handshake, or acceptance of a 0-length descriptor) loads the channel's counter with DONE_STRETCH.
  - The output is high while the counter is nonzero, starting the cycle after the event.
  - A retrigger while high reloads the counter; the output never glitches low.
- len_err is cleared only by rst.
- Width rules: the index counter is $clog2(BYTES+1) bits; length comparisons are done at LEN_W.

Decomposition:
- Shared package eth_udp_pkg holds the default constants (BYTES, LEN_W, GAP_CYCLES, DONE_STRETCH) and a clog2-safe channel-width function.
- One sub-module, pulse_stretcher (parameter STRETCH), is instantiated once per channel for done_stretch.
- Arbiter and FSM stay in the top.

Test Plan:
- Single frame: ch0 length 4, data MSBs 0xA1B2C3D4, tx_ready=1 → tx bytes A1,B2,C3,D4 on 4 consecutive cycles starting 1 cycle after accept. tx_last on D4, tx_length=4, done_stretch[0] high exactly 16 cycles.
- Backpressure: length 3, tx_ready toggled 1,0,0,1,1 → 3 handshakes; data, tx_last and tx_length held stable during stalls.
- Round robin: both channels valid continuously, length 2 → frame order ch0, ch1, ch0, ch1. At least 12 idle cycles between each tx_last and the next tx_valid.
- Boundaries:
  - length 0 → no tx_valid, done_stretch pulse issued.
  - length 200 with BYTES=120 → 120 bytes sent, tx_length=120, len_err=1 held until rst.
- Retrigger: ch1 frames of length 1 with GAP_CYCLES=0, every 3 cycles → done_stretch[1] continuously high, falling 16 cycles after the final done.
- Reset mid-frame: rst at byte 2 of 10 → next cycle tx_valid=0, in_ready=0, pointer=0, len_err=0. A new frame after reset starts at byte 0.

Source files
------------

// File: rtl/eth_udp_pkg.sv
// Shared constants, FSM state type and helpers for the UDP send path.
// Defaults: payload width, length width, inter-frame gap, done stretch.
package eth_udp_pkg;

  localparam int DEF_BYTES        = 120;
  localparam int DEF_LEN_W        = 16;
  localparam int DEF_GAP_CYCLES   = 12;
  localparam int DEF_DONE_STRETCH = 16;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } tx_state_t;

  // Channel index width, never below one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/udp_tx_payload_serializer_stretch.sv
// pulse_stretcher: holds stretched high for STRETCH cycles after trig.
// Ports: clk, rst (sync, active high), trig, stretched.
module pulse_stretcher #(
  parameter int STRETCH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic stretched
);

  localparam int SW = $clog2(STRETCH + 1);

  logic [SW-1:0] cnt;

  // A trigger always reloads, so back-to-back events never dip low.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (trig) begin
      cnt <= SW'(STRETCH);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign stretched = (cnt != '0);

endmodule

// File: rtl/udp_tx_payload_serializer.sv
// Round-robin payload serializer: NUM_CH wide descriptors -> byte stream.
// Ports: rgmii_clk/rst, in_valid/in_ready/in_data/in_length per channel,
// tx_valid/tx_ready/tx_data/tx_last/tx_length/tx_chan, done_stretch, len_err.
module udp_tx_payload_serializer
  import eth_udp_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int BYTES        = DEF_BYTES,
  parameter int LEN_W        = DEF_LEN_W,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int DONE_STRETCH = DEF_DONE_STRETCH
) (
  input  logic                      rgmii_clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         in_valid,
  output logic [NUM_CH-1:0]         in_ready,
  input  logic [NUM_CH*BYTES*8-1:0] in_data,
  input  logic [NUM_CH*LEN_W-1:0]   in_length,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [7:0]                tx_data,
  output logic                      tx_last,
  output logic [LEN_W-1:0]          tx_length,
  output logic [ch_w(NUM_CH)-1:0]   tx_chan,
  output logic [NUM_CH-1:0]         done_stretch,
  output logic                      len_err
);

  localparam int CW = ch_w(NUM_CH);
  localparam int DW = BYTES * 8;
  localparam int IW = $clog2(BYTES + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GLD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(BYTES);

  tx_state_t state, state_nxt, post;

  logic [CW-1:0]    ptr, gnt;
  logic             gnt_any;
  logic [DW-1:0]    shreg, sel_data;
  logic [IW-1:0]    idx;
  logic [LEN_W-1:0] len, sel_len, clamp_len;
  logic [GW-1:0]    gcnt;
  logic             xfer, hs, last_hs;
  logic [NUM_CH-1:0] done_evt;

  // First valid channel at or above ptr, wrapping.
  always_comb begin : arb
    logic [CW-1:0] c;
    c = ptr;
    gnt = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!gnt_any && in_valid[c]) begin
        gnt = c;
        gnt_any = 1'b1;
      end
      c = (c == CW'(NUM_CH - 1)) ? '0 : c + 1'b1;
    end
  end

  always_comb begin
    sel_len = '0;
    sel_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt == CW'(c)) begin
        sel_len = in_length[c*LEN_W +: LEN_W];
        sel_data = in_data[c*DW +: DW];
      end
    end
  end

  assign clamp_len = (sel_len > MAX_LEN) ? MAX_LEN : sel_len;

  always_comb begin
    in_ready = '0;
    if (state == IDLE && gnt_any && !rst) begin
      in_ready[gnt] = 1'b1;
    end
  end

  assign xfer = |(in_ready & in_valid);

  assign tx_valid = (state == SEND);
  assign tx_data = shreg[DW-1 -: 8];
  assign tx_last = tx_valid && (LEN_W'(idx) == len - 1'b1);
  assign tx_length = len;
  assign hs = tx_valid && tx_ready;
  assign last_hs = hs && tx_last;

  always_comb begin
    done_evt = '0;
    if (last_hs) begin
      done_evt[tx_chan] = 1'b1;
    end
    if (xfer && clamp_len == '0) begin
      done_evt[gnt] = 1'b1;
    end
  end

  always_ff @(posedge rgmii_clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    post = IDLE;
    if (GAP_CYCLES > 0) begin
      post = GAP;
    end
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (xfer) begin
          state_nxt = (clamp_len == '0) ? post : SEND;
        end
      end
      SEND: begin
        if (last_hs) begin
          state_nxt = post;
        end
      end
      GAP: begin
        if (gcnt == '0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rgmii_clk) begin
    if (rst) begin
      ptr     <= '0;
      shreg   <= '0;
      len     <= '0;
      idx     <= '0;
      tx_chan <= '0;
      gcnt    <= '0;
      len_err <= 1'b0;
    end else begin
      if (xfer) begin
        shreg   <= sel_data;
        len     <= clamp_len;
        tx_chan <= gnt;
        idx     <= '0;
        ptr     <= (gnt == CW'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
        if (sel_len > MAX_LEN) begin
          len_err <= 1'b1;
        end
      end
      // Shift MSB-first so the next byte is always on top.
      if (hs) begin
        if (tx_last) begin
          idx <= '0;
        end else begin
          idx   <= idx + 1'b1;
          shreg <= shreg << 8;
        end
      end
      // Preloaded outside GAP; GAP lasts GLD+1 cycles.
      if (state != GAP) begin
        gcnt <= GW'(GLD);
      end else if (gcnt != '0) begin
        gcnt <= gcnt - 1'b1;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_done
    pulse_stretcher #(
      .STRETCH(DONE_STRETCH)
    ) u_ps (
      .clk      (rgmii_clk),
      .rst      (rst),
      .trig     (done_evt[c]),
      .stretched(done_stretch[c])
    );
  end

endmodule
